// File: rtl/mem_ahb_ctrl_pkg.sv
// Shared types and helpers for the AHB-Lite SRAM controller.
// Transfer decode, byte-lane and error rules.
package mem_ahb_ctrl_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'd0,
    HT_BUSY   = 2'd1,
    HT_NONSEQ = 2'd2,
    HT_SEQ    = 2'd3
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_WAIT,
    ST_ERR1,
    ST_ERR2
  } ctrl_state_e;

  // Little-endian lane mask for a sized access; 8 lanes max.
  function automatic logic [7:0] size_to_be(
    input logic [2:0] hsize,
    input logic [2:0] addr_lo,
    input int         data
  );
    logic [15:0] m;
    m = (16'd1 << (4'd1 << hsize)) - 16'd1;
    m = m << addr_lo;
    if (data == 32)
      return {4'b0000, m[3:0]};
    return m[7:0];
  endfunction

  // Oversize, misaligned or out-of-range access.
  function automatic logic is_err(
    input logic [2:0]  hsize,
    input logic [63:0] haddr,
    input int          mem_bytes,
    input int          data
  );
    logic [2:0]  lb;
    logic [63:0] mask;
    logic        bad_size;
    logic        bad_align;
    logic        bad_range;
    lb        = (data == 64) ? 3'd3 : 3'd2;
    mask      = (64'd1 << hsize) - 64'd1;
    bad_size  = hsize > lb;
    bad_align = (haddr & mask) != 64'd0;
    bad_range = haddr >= 64'(mem_bytes);
    return bad_size | bad_align | bad_range;
  endfunction

endpackage

// File: rtl/mem_ahb_ctrl_if.sv
// AHB-Lite slave bus plus SRAM-side signals.
// slave = controller view, master = bus/SRAM view.
interface mem_ahb_ctrl_if #(
  parameter int ADDR = 32,
  parameter int DATA = 32,
  parameter int AW   = 10
);
  logic                hsel;
  logic [1:0]          htrans;
  logic [2:0]          hburst;
  logic [2:0]          hsize;
  logic [3:0]          hprot;
  logic                hmastlock;
  logic [ADDR-1:0]     haddr;
  logic                hwrite;
  logic [DATA-1:0]     hwdata;
  logic [DATA-1:0]     hrdata;
  logic                hresp;
  logic                hreadyout;
  logic                hready;
  logic                mem_req;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [DATA/8-1:0]   mem_be;
  logic [DATA-1:0]     mem_wdata;
  logic [DATA-1:0]     mem_rdata;

  modport slave (
    input  hsel, htrans, hburst, hsize,
    input  hprot, hmastlock, haddr,
    input  hwrite, hwdata, hready,
    input  mem_rdata,
    output hrdata, hresp, hreadyout,
    output mem_req, mem_we, mem_addr,
    output mem_be, mem_wdata
  );

  modport master (
    output hsel, htrans, hburst, hsize,
    output hprot, hmastlock, haddr,
    output hwrite, hwdata, hready,
    output mem_rdata,
    input  hrdata, hresp, hreadyout,
    input  mem_req, mem_we, mem_addr,
    input  mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_ahb_ctrl.sv
// AHB-Lite slave sequencing a single-port sync SRAM.
// Zero-wait writes, RD_LAT-wait reads, two-cycle ERROR.
module mem_ahb_ctrl
  import mem_ahb_ctrl_pkg::*;
#(
  parameter int ADDR      = 32,
  parameter int DATA      = 32,
  parameter int MEM_BYTES = 4096,
  parameter int RD_LAT    = 1
) (
  input  logic         hclk,
  input  logic         hreset_n,
  mem_ahb_ctrl_if.slave bus
);

  localparam int NB = DATA / 8;
  localparam int LB = $clog2(NB);
  localparam int AW = $clog2(MEM_BYTES / NB);
  localparam int CW = 3;

  ctrl_state_e   state;
  ctrl_state_e   state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [AW-1:0] waddr;
  logic [NB-1:0] be;

  logic            ready;
  logic            resp;
  logic [DATA-1:0] rdata;
  logic            req;
  logic            we;
  logic [AW-1:0]   maddr;
  logic [NB-1:0]   mbe;
  logic [DATA-1:0] mwdata;

  logic ahb_act;
  logic accept;
  logic err;
  logic go_err;
  logic go_wr;
  logic go_rd;
  logic hold_rd;
  logic unused_ok;

  assign unused_ok = ^{bus.hburst,
                       bus.hprot,
                       bus.hmastlock};

  assign ahb_act = bus.htrans == HT_NONSEQ
                || bus.htrans == HT_SEQ;

  assign err = is_err(bus.hsize,
                      64'(bus.haddr),
                      MEM_BYTES, DATA);

  // State register and address-phase capture.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      waddr <= '0;
      be    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        waddr <= bus.haddr[AW+LB-1:LB];
        be    <= NB'(size_to_be(
                   bus.hsize,
                   3'(bus.haddr[LB-1:0]),
                   DATA));
      end
    end
  end

  // Data-phase outputs and next-state choice.
  always_comb begin
    ready   = 1'b1;
    resp    = HRESP_OKAY;
    rdata   = '0;
    req     = 1'b0;
    we      = 1'b0;
    maddr   = '0;
    mbe     = '0;
    mwdata  = '0;
    state_n = ST_IDLE;
    cnt_n   = '0;

    unique case (state)
      ST_WR: begin
        req    = 1'b1;
        we     = 1'b1;
        maddr  = waddr;
        mbe    = be;
        mwdata = bus.hwdata;
      end
      ST_RD_WAIT: begin
        if (cnt != '0)
          ready = 1'b0;
        else
          rdata = bus.mem_rdata;
        if (cnt == CW'(RD_LAT)) begin
          req   = 1'b1;
          maddr = waddr;
        end
      end
      ST_ERR1: begin
        ready = 1'b0;
        resp  = HRESP_ERROR;
      end
      ST_ERR2: begin
        resp = HRESP_ERROR;
      end
      default: ;
    endcase

    accept  = ready & bus.hsel
            & bus.hready & ahb_act;
    go_err  = accept & err;
    go_wr   = accept & ~err & bus.hwrite;
    go_rd   = accept & ~err & ~bus.hwrite;
    hold_rd = (state == ST_RD_WAIT)
            & (cnt != '0);

    unique case (1'b1)
      (state == ST_ERR1): state_n = ST_ERR2;
      hold_rd: begin
        state_n = ST_RD_WAIT;
        cnt_n   = cnt - CW'(1);
      end
      go_err: state_n = ST_ERR1;
      go_wr:  state_n = ST_WR;
      go_rd: begin
        state_n = ST_RD_WAIT;
        cnt_n   = CW'(RD_LAT);
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.hreadyout = ready;
  assign bus.hresp     = resp;
  assign bus.hrdata    = rdata;
  assign bus.mem_req   = req;
  assign bus.mem_we    = we;
  assign bus.mem_addr  = maddr;
  assign bus.mem_be    = mbe;
  assign bus.mem_wdata = mwdata;

endmodule

// File: tb/tb_mem_ahb_ctrl.sv
// Bench for mem_ahb_ctrl: directed plan plus random
// transfers checked against a byte-level memory model.
module tb_mem_ahb_ctrl;
  import mem_ahb_ctrl_pkg::*;

  localparam int RD_LAT    = 2;
  localparam int MEM_BYTES = 4096;

  typedef enum int {K_NONE, K_WR, K_RD, K_ERR} kind_e;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;

  always #5 clk = ~clk;

  mem_ahb_ctrl_if #(.ADDR(32), .DATA(32), .AW(10)) bus ();

  mem_ahb_ctrl #(
    .ADDR(32), .DATA(32),
    .MEM_BYTES(MEM_BYTES), .RD_LAT(RD_LAT)
  ) dut (
    .hclk(clk),
    .hreset_n(rst_n),
    .bus(bus)
  );

  assign bus.hready = bus.hreadyout;

  // SRAM model with RD_LAT-deep read pipe
  logic [31:0] sram  [0:1023];
  logic [31:0] rpipe [0:RD_LAT-1];

  assign bus.mem_rdata = rpipe[RD_LAT-1];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) sram[i] <= '0;
      for (int i = 0; i < RD_LAT; i++) rpipe[i] <= '0;
    end else begin
      if (bus.mem_req && bus.mem_we)
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b])
            sram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      if (bus.mem_req && !bus.mem_we)
        rpipe[0] <= sram[bus.mem_addr];
      for (int i = 1; i < RD_LAT; i++)
        rpipe[i] <= rpipe[i-1];
    end
  end

  logic [7:0] ref_mem [0:MEM_BYTES-1];
  int n_vec;
  int n_bad;

  kind_e       p_kind;
  logic [31:0] p_addr;
  logic [31:0] p_wdata;
  logic [3:0]  p_be;
  logic [31:0] last_rdata;
  logic [3:0]  last_be;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input int sz,
                                     input logic [31:0] a);
    logic [31:0] n;
    n = 32'd1 << sz;
    return sz > 2 || (a % n) != 0 || a >= MEM_BYTES;
  endfunction

  function automatic logic [3:0] model_be(input int sz,
                                          input logic [31:0] a);
    logic [3:0] r;
    int off;
    int n;
    off = int'(a[1:0]);
    n   = 1 << sz;
    for (int b = 0; b < 4; b++)
      r[b] = (b >= off) && (b < off + n);
    return r;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int base;
    base = int'(a) / 4 * 4;
    return {ref_mem[base+3], ref_mem[base+2],
            ref_mem[base+1], ref_mem[base]};
  endfunction

  task automatic ref_write(input logic [31:0] a,
                           input logic [3:0] m,
                           input logic [31:0] d);
    int base;
    base = int'(a) / 4 * 4;
    for (int b = 0; b < 4; b++)
      if (m[b]) ref_mem[base+b] = d[8*b +: 8];
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_hreadyout"}, bus.hreadyout, 1);
    chk({tag, "_hresp"},     bus.hresp, 0);
    chk({tag, "_hrdata"},    bus.hrdata, 0);
    chk({tag, "_mem_req"},   bus.mem_req, 0);
    chk({tag, "_mem_we"},    bus.mem_we, 0);
    chk({tag, "_mem_be"},    bus.mem_be, 0);
    chk({tag, "_mem_addr"},  bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
  endtask

  // Drive one address phase while checking the data phase
  // of the previously accepted transfer.
  task automatic issue(input logic sel,
                       input logic [1:0] trans,
                       input logic wr,
                       input logic [2:0] sz,
                       input logic [31:0] a,
                       input logic [31:0] wd);
    int w;
    bus.hsel      = sel;
    bus.htrans    = trans;
    bus.hwrite    = wr;
    bus.hsize     = sz;
    bus.haddr     = a;
    bus.hburst    = 3'($urandom);
    bus.hprot     = 4'($urandom);
    bus.hmastlock = 1'($urandom);
    bus.hwdata    = (p_kind == K_WR) ? p_wdata : $urandom;
    w = (p_kind == K_RD) ? RD_LAT : (p_kind == K_ERR) ? 1 : 0;
    for (int k = 0; k <= w; k++) begin
      @(negedge clk);
      chk("hreadyout", bus.hreadyout, k == w);
      case (p_kind)
        K_NONE: begin
          chk("idle_hresp", bus.hresp, 0);
          chk("idle_req", bus.mem_req, 0);
          chk("idle_be", bus.mem_be, 0);
          chk("idle_hrdata", bus.hrdata, 0);
        end
        K_WR: begin
          chk("wr_hresp", bus.hresp, 0);
          chk("wr_req", bus.mem_req, 1);
          chk("wr_we", bus.mem_we, 1);
          chk("wr_be", bus.mem_be, p_be);
          chk("wr_addr", bus.mem_addr, p_addr[11:2]);
          chk("wr_wdata", bus.mem_wdata, p_wdata);
          chk("wr_hrdata", bus.hrdata, 0);
          last_be = bus.mem_be;
          ref_write(p_addr, p_be, p_wdata);
        end
        K_RD: begin
          chk("rd_hresp", bus.hresp, 0);
          chk("rd_req", bus.mem_req, k == 0);
          chk("rd_be", bus.mem_be, 0);
          if (k == 0) begin
            chk("rd_we", bus.mem_we, 0);
            chk("rd_addr", bus.mem_addr, p_addr[11:2]);
          end
          if (k == w) begin
            chk("rd_hrdata", bus.hrdata, ref_word(p_addr));
            last_rdata = bus.hrdata;
          end else begin
            chk("rd_wait_hrdata", bus.hrdata, 0);
          end
        end
        K_ERR: begin
          chk("err_hresp", bus.hresp, 1);
          chk("err_req", bus.mem_req, 0);
          chk("err_hrdata", bus.hrdata, 0);
        end
        default: ;
      endcase
      if (k < w) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    if (sel && trans[1]) begin
      p_addr  = a;
      p_wdata = wd;
      p_be    = model_be(int'(sz), a);
      p_kind  = model_err(int'(sz), a) ? K_ERR
              : (wr ? K_WR : K_RD);
    end else begin
      p_kind = K_NONE;
    end
    #1;
  endtask

  task automatic flush();
    issue(1'b0, HT_IDLE, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  initial begin
    logic        sel;
    logic [1:0]  tr;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] mask;

    n_vec  = 0;
    n_bad  = 0;
    p_kind = K_NONE;
    p_addr = '0;
    p_wdata = '0;
    p_be   = '0;
    last_rdata = '0;
    last_be = '0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = '0;
    bus.hsel = 0; bus.htrans = 0; bus.hwrite = 0;
    bus.hsize = 0; bus.haddr = 0; bus.hwdata = 0;
    bus.hburst = 0; bus.hprot = 0; bus.hmastlock = 0;
    clr   = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_reset("reset");
    repeat (2) @(posedge clk);
    #1;
    clr   = 1'b0;
    rst_n = 1'b1;

    // word write then word read
    issue(1, HT_NONSEQ, 1, 3'd2, 32'h10, 32'hDEADBEEF);
    issue(1, HT_NONSEQ, 0, 3'd2, 32'h10, 32'h0);
    chk("be_word", last_be, 4'hF);
    issue(1, HT_NONSEQ, 1, 3'd0, 32'h13, 32'hAA000000);
    chk("rd_10_first", last_rdata, 32'hDEADBEEF);
    issue(1, HT_NONSEQ, 1, 3'd1, 32'h20, 32'h00001234);
    chk("be_byte", last_be, 4'h8);
    issue(1, HT_NONSEQ, 0, 3'd2, 32'h10, 32'h0);
    chk("be_half", last_be, 4'h3);
    flush();
    chk("rd_10_merged", last_rdata, 32'hAAADBEEF);

    // error responses
    issue(1, HT_NONSEQ, 0, 3'd1, 32'h11, 32'h0);
    issue(1, HT_NONSEQ, 1, 3'd3, 32'h18, 32'h0);
    issue(1, HT_NONSEQ, 0, 3'd2, 32'h1000, 32'h0);
    flush();

    // burst writes then IDLE/BUSY
    issue(1, HT_NONSEQ, 1, 3'd2, 32'h40, 32'h11111111);
    issue(1, HT_SEQ,    1, 3'd2, 32'h44, 32'h22222222);
    issue(1, HT_SEQ,    1, 3'd2, 32'h48, 32'h33333333);
    issue(1, HT_IDLE,   1, 3'd2, 32'h4C, 32'h0);
    issue(1, HT_BUSY,   1, 3'd2, 32'h4C, 32'h0);
    flush();

    // address phase held across read waits
    issue(1, HT_NONSEQ, 0, 3'd2, 32'h40, 32'h0);
    issue(1, HT_NONSEQ, 1, 3'd2, 32'h50, 32'h50505050);
    issue(1, HT_NONSEQ, 0, 3'd2, 32'h50, 32'h0);
    flush();
    chk("rd_50", last_rdata, 32'h50505050);

    // random traffic
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 7) != 0;
      tr  = 2'($urandom_range(0, 3));
      wr  = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 9) == 0) ? 3'd3
          : 3'($urandom_range(0, 2));
      a   = ($urandom_range(0, 15) == 0)
          ? 32'h1000 + $urandom_range(0, 255)
          : $urandom_range(0, 127);
      mask = (32'd1 << sz) - 32'd1;
      if ($urandom_range(0, 3) != 0) a = a & ~mask;
      issue(sel, tr, wr, sz, a, $urandom);
    end
    flush();

    // reset during a read wait
    issue(1, HT_NONSEQ, 0, 3'd2, 32'h10, 32'h0);
    bus.hsel = 0;
    bus.htrans = HT_IDLE;
    #2 rst_n = 1'b0;
    #1 check_reset("rst_rd");
    @(posedge clk);
    #1 rst_n = 1'b1;
    p_kind = K_NONE;
    flush();

    // reset during a write data phase
    issue(1, HT_NONSEQ, 1, 3'd2, 32'h60, 32'h12345678);
    bus.hsel = 0;
    bus.htrans = HT_IDLE;
    bus.hwdata = 32'h12345678;
    #2 rst_n = 1'b0;
    #1 check_reset("rst_wr");
    @(posedge clk);
    #1 rst_n = 1'b1;
    p_kind = K_NONE;
    chk("no_partial", sram[10'h18], ref_word(32'h60));
    issue(1, HT_NONSEQ, 0, 3'd2, 32'h60, 32'h0);
    flush();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
